// File: rtl/lcd_pkg.sv
// Shared types, timing defaults and helpers for the LCD bus engine.
package lcd_pkg;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned T_AS_DEF = 2;
  localparam int unsigned T_PW_DEF = 12;
  localparam int unsigned T_H_DEF  = 2;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_e;

  typedef struct packed {
    logic              rs;
    logic              rw;
    logic [DATA_W-1:0] data;
  } lcd_req_t;

  // Timer reload value for a phase of 'cycles' cycles; 0 is treated as 1.
  function automatic logic [CNT_W-1:0] phase_load(input int unsigned cycles);
    int unsigned c;
    c = cycles;
    if (c == 0) c = 1;
    else if (c > CNT_MAX) c = CNT_MAX;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Per-phase down-counter: load on start, done once the count reaches zero.
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else if (start_i) begin
      cnt_q  <= load_i;
      done_q <= (load_i == '0);
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      done_q <= (cnt_q == CNT_W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/lcd_bus_engine.sv
// HD44780-style LCD bus engine: one request becomes SETUP/PULSE/HOLD phases,
// one phase per byte on the 8-bit bus or two nibble phases in 4-bit mode.
module lcd_bus_engine
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS = T_AS_DEF,
  parameter int unsigned T_PW = T_PW_DEF,
  parameter int unsigned T_H  = T_H_DEF,
  parameter bit          BUS4 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rs,
  input  logic              req_rw,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic [DATA_W-1:0] lcd_db_out,
  output logic              lcd_db_oe,
  input  logic [DATA_W-1:0] lcd_db_in
);

  localparam logic [CNT_W-1:0] AS_LD = phase_load(T_AS);
  localparam logic [CNT_W-1:0] PW_LD = phase_load(T_PW);
  localparam logic [CNT_W-1:0] H_LD  = phase_load(T_H);

  lcd_state_e        state_q;
  lcd_req_t          req_q;
  logic              nib_q;
  logic [DATA_W-1:0] rd_q;
  logic              ready_q, en_q, rs_q, rw_q, oe_q, rsp_valid_q;
  logic [DATA_W-1:0] db_q, rsp_data_q;

  logic              tmr_start_c;
  logic [CNT_W-1:0]  tmr_load_c;
  logic              tmr_done;

  // Timer reload on every state entry.
  always_comb begin
    tmr_start_c = 1'b0;
    tmr_load_c  = '0;
    case (state_q)
      ST_IDLE:  if (req_valid) begin tmr_start_c = 1'b1; tmr_load_c = AS_LD; end
      ST_SETUP: if (tmr_done)  begin tmr_start_c = 1'b1; tmr_load_c = PW_LD; end
      ST_PULSE: if (tmr_done)  begin tmr_start_c = 1'b1; tmr_load_c = H_LD;  end
      ST_HOLD:  if (tmr_done && BUS4 && !nib_q) begin
        tmr_start_c = 1'b1;
        tmr_load_c  = AS_LD;
      end
      default: ;
    endcase
  end

  lcd_phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .start_i (tmr_start_c),
    .load_i  (tmr_load_c),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      nib_q       <= 1'b0;
      rd_q        <= '0;
      ready_q     <= 1'b1;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      db_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_q   <= '{rs: req_rs, rw: req_rw, data: req_data};
            nib_q   <= 1'b0;
            state_q <= ST_SETUP;
            ready_q <= 1'b0;
            rs_q    <= req_rs;
            rw_q    <= req_rw;
            oe_q    <= !req_rw;
            if (req_rw)    db_q <= '0;
            else if (BUS4) db_q <= {req_data[7:4], 4'h0};
            else           db_q <= req_data;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state_q <= ST_PULSE;
            en_q    <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tmr_done) begin
            state_q <= ST_HOLD;
            en_q    <= 1'b0;
            // Capture on the last EN-high cycle; nibbles arrive on DB[7:4].
            if (req_q.rw) begin
              if (!BUS4)      rd_q       <= lcd_db_in;
              else if (!nib_q) rd_q[7:4] <= lcd_db_in[7:4];
              else            rd_q[3:0]  <= lcd_db_in[7:4];
            end
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (BUS4 && !nib_q) begin
              nib_q   <= 1'b1;
              state_q <= ST_SETUP;
              db_q    <= req_q.rw ? '0 : {req_q.data[3:0], 4'h0};
            end else begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              rs_q    <= 1'b0;
              rw_q    <= 1'b0;
              oe_q    <= 1'b0;
              db_q    <= '0;
              if (req_q.rw) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rd_q;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = rw_q;
  assign lcd_en     = en_q;
  assign lcd_db_out = db_q;
  assign lcd_db_oe  = oe_q;

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Bench for lcd_bus_engine: three configurations checked every cycle against a
// timeline model, plus a transaction table and hand-written corner sequences.
module tb_lcd_bus_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       vld [3], rs_i [3], rw_i [3];
  logic [7:0] dat [3], dbi [3];
  logic       rdy [3], rsv [3], ors [3], orw [3], oen [3], ooe [3];
  logic [7:0] rsd [3], odb [3];

  int checks = 0;
  int errors = 0;

  // dut0: defaults 8-bit; dut1: 4-bit; dut2: T_AS=0 (clamped), T_PW=1, T_H=1
  lcd_bus_engine u0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_rs(rs_i[0]),
    .req_rw(rw_i[0]), .req_data(dat[0]), .rsp_valid(rsv[0]), .rsp_data(rsd[0]),
    .lcd_rs(ors[0]), .lcd_rw(orw[0]), .lcd_en(oen[0]), .lcd_db_out(odb[0]),
    .lcd_db_oe(ooe[0]), .lcd_db_in(dbi[0]));

  lcd_bus_engine #(.BUS4(1'b1)) u1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_rs(rs_i[1]),
    .req_rw(rw_i[1]), .req_data(dat[1]), .rsp_valid(rsv[1]), .rsp_data(rsd[1]),
    .lcd_rs(ors[1]), .lcd_rw(orw[1]), .lcd_en(oen[1]), .lcd_db_out(odb[1]),
    .lcd_db_oe(ooe[1]), .lcd_db_in(dbi[1]));

  lcd_bus_engine #(.T_AS(0), .T_PW(1), .T_H(1)) u2 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_rs(rs_i[2]),
    .req_rw(rw_i[2]), .req_data(dat[2]), .rsp_valid(rsv[2]), .rsp_data(rsd[2]),
    .lcd_rs(ors[2]), .lcd_rw(orw[2]), .lcd_en(oen[2]), .lcd_db_out(odb[2]),
    .lcd_db_oe(ooe[2]), .lcd_db_in(dbi[2]));

  // Reference model: each transfer is a timeline of nph*(AS+PW+H) busy cycles.
  int         m_as [3], m_pw [3], m_h [3];
  bit         m_b4 [3];
  bit         m_busy [3];
  int         m_off [3];
  logic       m_rs [3], m_rw [3], m_rv [3];
  logic [7:0] m_d [3], m_asm [3], m_rd [3];

  function automatic int clampc(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic chk(input string nm, input int i, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, i, $time, got, exp);
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < 3; i++) begin
      int p, r, ph, nph;
      logic nrv;
      if (rst) begin
        m_busy[i] = 1'b0;
        m_rv[i]   = 1'b0;
        m_rd[i]   = 8'h00;
        continue;
      end
      p   = m_as[i] + m_pw[i] + m_h[i];
      nph = m_b4[i] ? 2 : 1;
      nrv = 1'b0;
      if (m_busy[i]) begin
        r  = m_off[i] % p;
        ph = m_off[i] / p;
        if (m_rw[i] && r == m_as[i] + m_pw[i] - 1) begin
          if (!m_b4[i])     m_asm[i]      = dbi[i];
          else if (ph == 0) m_asm[i][7:4] = dbi[i][7:4];
          else              m_asm[i][3:0] = dbi[i][7:4];
        end
        m_off[i]++;
        if (m_off[i] == p * nph) begin
          m_busy[i] = 1'b0;
          if (m_rw[i]) begin
            nrv     = 1'b1;
            m_rd[i] = m_asm[i];
          end
        end
      end else if (vld[i]) begin
        m_busy[i] = 1'b1;
        m_off[i]  = 0;
        m_rs[i]   = rs_i[i];
        m_rw[i]   = rw_i[i];
        m_d[i]    = dat[i];
      end
      m_rv[i] = nrv;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int p, r, ph;
      logic e_en, e_rs, e_rw, e_oe, e_rdy;
      logic [7:0] e_db;
      if (m_busy[i]) begin
        p     = m_as[i] + m_pw[i] + m_h[i];
        r     = m_off[i] % p;
        ph    = m_off[i] / p;
        e_en  = (r >= m_as[i]) && (r < m_as[i] + m_pw[i]);
        e_rs  = m_rs[i];
        e_rw  = m_rw[i];
        e_oe  = !m_rw[i];
        e_rdy = 1'b0;
        if (m_rw[i])      e_db = 8'h00;
        else if (!m_b4[i]) e_db = m_d[i];
        else if (ph == 0) e_db = {m_d[i][7:4], 4'h0};
        else              e_db = {m_d[i][3:0], 4'h0};
      end else begin
        e_en = 1'b0; e_rs = 1'b0; e_rw = 1'b0; e_oe = 1'b0; e_rdy = 1'b1; e_db = 8'h00;
      end
      chk("req_ready", i, 8'(rdy[i]), 8'(e_rdy));
      chk("lcd_en",    i, 8'(oen[i]), 8'(e_en));
      chk("lcd_rs",    i, 8'(ors[i]), 8'(e_rs));
      chk("lcd_rw",    i, 8'(orw[i]), 8'(e_rw));
      chk("lcd_db_oe", i, 8'(ooe[i]), 8'(e_oe));
      chk("lcd_db_out", i, odb[i], e_db);
      chk("rsp_valid", i, 8'(rsv[i]), 8'(m_rv[i]));
      chk("rsp_data",  i, rsd[i], m_rd[i]);
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_ready(input int i);
    int g;
    g = 0;
    while (!rdy[i] && g < 200) begin tick(); g++; end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL wait_ready dut%0d got busy expected idle within 200 cycles", i);
    end
  endtask

  // One transfer on dut i with per-transfer counters of what the pins did.
  task automatic run_txn(input int i, input logic rs, input logic rw, input logic [7:0] data,
                         input logic [7:0] d1, input logic [7:0] d2,
                         output int pulses, output int en_cyc, output int busy,
                         output int oe_cyc, output int rvc,
                         output logic [7:0] db1, output logic [7:0] db2);
    int g;
    logic prev_en;
    pulses = 0; en_cyc = 0; busy = 0; oe_cyc = 0; rvc = 0; db1 = 8'h00; db2 = 8'h00;
    wait_ready(i);
    vld[i] = 1'b1; rs_i[i] = rs; rw_i[i] = rw; dat[i] = data; dbi[i] = d1;
    tick();
    vld[i] = 1'b0;
    prev_en = 1'b0;
    g = 0;
    while (!rdy[i] && g < 200) begin
      if (oen[i] && !prev_en) begin
        pulses++;
        if (pulses == 1) db1 = odb[i]; else db2 = odb[i];
      end
      if (!oen[i] && prev_en) dbi[i] = d2;
      if (oen[i]) en_cyc++;
      if (ooe[i]) oe_cyc++;
      if (rsv[i]) rvc++;
      busy++;
      prev_en = oen[i];
      tick();
      g++;
    end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL txn_timeout dut%0d got busy expected idle within 200 cycles", i);
    end
    if (rsv[i]) rvc++;
    tick();
    if (rsv[i]) rvc++;
  endtask

  typedef struct {
    int         dut;
    logic       rs, rw;
    logic [7:0] data, d1, d2;
    int         e_pulses, e_en, e_busy;
    logic [7:0] e_db1, e_db2, e_rsp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int pl, ec, bc, oc, rc, idle, g;
    logic [7:0] b1, b2;
    int raw_as [3], raw_pw [3], raw_h [3];

    raw_as = '{2, 2, 0}; raw_pw = '{12, 12, 1}; raw_h = '{2, 2, 1};
    for (int i = 0; i < 3; i++) begin
      m_as[i] = clampc(raw_as[i]); m_pw[i] = clampc(raw_pw[i]); m_h[i] = clampc(raw_h[i]);
      m_b4[i] = (i == 1);
      m_busy[i] = 1'b0; m_off[i] = 0; m_rv[i] = 1'b0; m_rd[i] = 8'h00; m_asm[i] = 8'h00;
      m_rs[i] = 1'b0; m_rw[i] = 1'b0; m_d[i] = 8'h00;
      vld[i] = 1'b0; rs_i[i] = 1'b0; rw_i[i] = 1'b0; dat[i] = 8'h00; dbi[i] = 8'h00;
    end

    //        dut rs    rw    data   d1     d2     pl en  busy db1    db2    rsp
    tbl[0] = '{0, 1'b0, 1'b0, 8'h38, 8'h00, 8'h00, 1, 12, 16, 8'h38, 8'h00, 8'h00};
    tbl[1] = '{0, 1'b1, 1'b1, 8'h00, 8'h5A, 8'h5A, 1, 12, 16, 8'h00, 8'h00, 8'h5A};
    tbl[2] = '{1, 1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 2, 24, 32, 8'hA0, 8'h50, 8'h00};
    tbl[3] = '{1, 1'b0, 1'b1, 8'h00, 8'h8F, 8'h0F, 2, 24, 32, 8'h00, 8'h00, 8'h80};
    tbl[4] = '{1, 1'b1, 1'b1, 8'h00, 8'h3C, 8'hE1, 2, 24, 32, 8'h00, 8'h00, 8'h3E};
    tbl[5] = '{2, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 1, 1,  3,  8'h01, 8'h00, 8'h00};
    tbl[6] = '{2, 1'b0, 1'b1, 8'h00, 8'hC3, 8'hC3, 1, 1,  3,  8'h00, 8'h00, 8'hC3};
    tbl[7] = '{1, 1'b0, 1'b0, 8'h0F, 8'h00, 8'h00, 2, 24, 32, 8'h00, 8'hF0, 8'h00};

    #1 rst = 1'b1;
    @(negedge clk);
    check_all();
    tick();
    rst = 1'b0;
    tick();

    // Transaction table
    for (int k = 0; k < 8; k++) begin
      run_txn(tbl[k].dut, tbl[k].rs, tbl[k].rw, tbl[k].data, tbl[k].d1, tbl[k].d2,
              pl, ec, bc, oc, rc, b1, b2);
      chk("tbl_pulses", tbl[k].dut, 8'(pl), 8'(tbl[k].e_pulses));
      chk("tbl_en_cycles", tbl[k].dut, 8'(ec), 8'(tbl[k].e_en));
      chk("tbl_busy", tbl[k].dut, 8'(bc), 8'(tbl[k].e_busy));
      chk("tbl_oe_cycles", tbl[k].dut, 8'(oc), tbl[k].rw ? 8'd0 : 8'(tbl[k].e_busy));
      chk("tbl_rsp_pulses", tbl[k].dut, 8'(rc), tbl[k].rw ? 8'd1 : 8'd0);
      chk("tbl_db1", tbl[k].dut, b1, tbl[k].e_db1);
      chk("tbl_db2", tbl[k].dut, b2, tbl[k].e_db2);
      if (tbl[k].rw) chk("tbl_rsp_data", tbl[k].dut, rsd[tbl[k].dut], tbl[k].e_rsp);
    end

    // Back-to-back writes with req_valid held high
    wait_ready(0);
    vld[0] = 1'b1; rs_i[0] = 1'b1; rw_i[0] = 1'b0; dat[0] = 8'h11;
    tick();
    dat[0] = 8'h22;
    g = 0;
    while (!rdy[0] && g < 200) begin tick(); g++; end
    idle = 0;
    while (rdy[0] && idle < 50) begin idle++; tick(); end
    vld[0] = 1'b0;
    chk("b2b_idle_cycles", 0, 8'(idle), 8'd1);
    chk("b2b_second_db", 0, odb[0], 8'h22);
    wait_ready(0);

    // Reset on the 5th EN-high cycle of a read
    vld[0] = 1'b1; rs_i[0] = 1'b1; rw_i[0] = 1'b1; dat[0] = 8'h00; dbi[0] = 8'h77;
    tick();
    vld[0] = 1'b0;
    repeat (6) tick();
    chk("rst_pre_en", 0, 8'(oen[0]), 8'd1);
    rst = 1'b1;
    #1;
    chk("rst_en_drop", 0, 8'(oen[0]), 8'd0);
    chk("rst_rsp_valid", 0, 8'(rsv[0]), 8'd0);
    chk("rst_ready", 0, 8'(rdy[0]), 8'd1);
    tick();
    rst = 1'b0;
    tick();
    run_txn(0, 1'b0, 1'b0, 8'h5C, 8'h00, 8'h00, pl, ec, bc, oc, rc, b1, b2);
    chk("post_rst_en", 0, 8'(ec), 8'd12);
    chk("post_rst_busy", 0, 8'(bc), 8'd16);
    chk("post_rst_db", 0, b1, 8'h5C);
    chk("post_rst_rsp", 0, 8'(rc), 8'd0);

    // Randomized traffic on all three engines with occasional resets
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 3; i++) begin
        vld[i]  = ($urandom_range(0, 3) == 0);
        rs_i[i] = 1'($urandom_range(0, 1));
        rw_i[i] = 1'($urandom_range(0, 1));
        dat[i]  = 8'($urandom);
        dbi[i]  = 8'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
